// File: rtl/alu_issue_ctrl.sv
// Sequential issue front end for the combinational ALU: takes one request per handshake, sequences
// operands then opcode, waits the settle time, captures z_hi/z_lo. Optional z_zero flag: ALU_ISSUE_ZFLAG_EN.
module alu_issue_ctrl #(
   parameter int unsigned MULDIV_CYCLES = 32,
   parameter int unsigned SIMPLE_CYCLES = 1
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_ctl,
   input  logic [31:0] req_a,
   input  logic [31:0] req_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_ctl,
   input  logic [63:0] alu_c,
   output logic [31:0] z_hi,
   output logic [31:0] z_lo,
`ifdef ALU_ISSUE_ZFLAG_EN
   output logic        z_zero,
`endif
   output logic        done,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ERR   = 2'd3
   } state_t;

   localparam logic [3:0] OP_MUL = 4'd3;
   localparam logic [3:0] OP_DIV = 4'd4;
   localparam logic [3:0] OP_MAX = 4'd12;

   localparam logic [7:0] MULDIV_LOAD = 8'(MULDIV_CYCLES - 1);
   localparam logic [7:0] SIMPLE_LOAD = 8'(SIMPLE_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] op_q;
   logic [7:0] cnt;

   logic       accept;
   logic       op_legal;
   logic       capture;
   logic [7:0] cnt_load;

   assign req_ready = (state == IDLE);
   assign busy      = (state == ISSUE) || (state == WAIT);

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      capture    = 1'b0;
      op_legal   = (req_ctl != 4'd0) && (req_ctl <= OP_MAX);
      cnt_load   = ((op_q == OP_MUL) || (op_q == OP_DIV)) ? MULDIV_LOAD : SIMPLE_LOAD;
      case (state)
         IDLE: begin
            if (req_valid) begin
               accept     = 1'b1;
               state_next = op_legal ? ISSUE : ERR;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT: begin
            if (cnt == 8'd0) begin
               capture    = 1'b1;
               state_next = IDLE;
            end
         end
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (clr) begin
         alu_a   <= '0;
         alu_b   <= '0;
         alu_ctl <= '0;
         op_q    <= '0;
         cnt     <= '0;
         z_hi    <= '0;
         z_lo    <= '0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         done <= capture || (state == ERR);
         err  <= (state == ERR);

         if (accept && op_legal) begin
            alu_a <= req_a;
            alu_b <= req_b;
            op_q  <= req_ctl;
         end

         // Opcode lands one edge after the operands so the ALU sees stable inputs on the ctl transition.
         if (state == ISSUE) begin
            alu_ctl <= op_q;
            cnt     <= cnt_load;
         end else if (state == WAIT) begin
            if (capture) begin
               z_hi    <= alu_c[63:32];
               z_lo    <= alu_c[31:0];
               alu_ctl <= '0;
            end else begin
               cnt <= cnt - 8'd1;
            end
         end
      end
   end

`ifdef ALU_ISSUE_ZFLAG_EN
   always_ff @(posedge clk) begin
      if (clr) begin
         z_zero <= 1'b0;
      end else if (capture) begin
         z_zero <= (alu_c == 64'h0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed and random ops against a transaction-level
// reference (expected result and done latency per request) with a behavioural ALU driving alu_c.
module tb_alu_issue_ctrl;

   localparam int unsigned MULDIV = 32;
   localparam int unsigned SIMPLE = 1;

   logic        clk;
   logic        clr;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_ctl;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctl;
   logic [63:0] alu_c;
   logic [31:0] z_hi;
   logic [31:0] z_lo;
`ifdef ALU_ISSUE_ZFLAG_EN
   logic        z_zero;
`endif
   logic        done;
   logic        busy;
   logic        err;

   int unsigned errors = 0;
   int unsigned checks = 0;

   logic [63:0] exp_z  = 64'h0;
   logic        exp_zz = 1'b0;

   alu_issue_ctrl #(
      .MULDIV_CYCLES(MULDIV),
      .SIMPLE_CYCLES(SIMPLE)
   ) dut (
      .clk      (clk),
      .clr      (clr),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_ctl  (req_ctl),
      .req_a    (req_a),
      .req_b    (req_b),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctl  (alu_ctl),
      .alu_c    (alu_c),
      .z_hi     (z_hi),
      .z_lo     (z_lo),
`ifdef ALU_ISSUE_ZFLAG_EN
      .z_zero   (z_zero),
`endif
      .done     (done),
      .busy     (busy),
      .err      (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [63:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] s;
      s = b[4:0];
      case (c)
         4'd1:    return {32'h0, a + b};
         4'd2:    return {32'h0, a - b};
         4'd3:    return {32'h0, a} * {32'h0, b};
         4'd4:    return (b == 32'h0) ? 64'h0 : {a % b, a / b};
         4'd5:    return {32'h0, a >> s};
         4'd6:    return {32'h0, a << s};
         4'd7:    return {32'h0, (a >> s) | (a << (6'd32 - {1'b0, s}))};
         4'd8:    return {32'h0, (a << s) | (a >> (6'd32 - {1'b0, s}))};
         4'd9:    return {32'h0, a & b};
         4'd10:   return {32'h0, a | b};
         4'd11:   return {32'h0, ~a};
         4'd12:   return {32'h0, 32'h0 - a};
         default: return 64'h0;
      endcase
   endfunction

   always_comb alu_c = alu_fn(alu_ctl, alu_a, alu_b);

   function automatic int settle(input logic [3:0] c);
      return ((c == 4'd3) || (c == 4'd4)) ? MULDIV : SIMPLE;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_z();
      check("z_hi", {32'h0, z_hi}, {32'h0, exp_z[63:32]});
      check("z_lo", {32'h0, z_lo}, {32'h0, exp_z[31:0]});
`ifdef ALU_ISSUE_ZFLAG_EN
      check("z_zero", {63'h0, z_zero}, {63'h0, exp_zz});
`endif
   endtask

   // Called just after a negedge; returns just after the negedge on which done is seen.
   task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input bit junk);
      bit legal;
      int k;
      int exp_k;
      legal = (c >= 4'd1) && (c <= 4'd12);
      exp_k = legal ? settle(c) + 1 : 1;
      check("ready_before", {63'h0, req_ready}, 64'h1);
      req_valid = 1'b1;
      req_ctl   = c;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("ready_after_accept", {63'h0, req_ready}, 64'h0);
      check("ctl_after_accept", {60'h0, alu_ctl}, 64'h0);
      if (legal) begin
         check("busy", {63'h0, busy}, 64'h1);
         check("alu_a", {32'h0, alu_a}, {32'h0, a});
         check("alu_b", {32'h0, alu_b}, {32'h0, b});
      end else begin
         check("done_early", {63'h0, done}, 64'h0);
      end
      k = 0;
      while (!done && k < 300) begin
         if (junk) begin
            req_valid = 1'b1;
            req_ctl   = 4'($urandom);
            req_a     = $urandom;
            req_b     = $urandom;
         end
         @(negedge clk);
         k++;
         if (k == 1) check("ctl_issue", {60'h0, alu_ctl}, legal ? {60'h0, c} : 64'h0);
         if (!done) check("ready_in_flight", {63'h0, req_ready}, 64'h0);
      end
      req_valid = 1'b0;
      check("done_latency", 64'(k), 64'(exp_k));
      if (legal) begin
         exp_z  = alu_fn(c, a, b);
         exp_zz = (exp_z == 64'h0);
      end
      check("err", {63'h0, err}, {63'h0, !legal});
      check("ctl_after_done", {60'h0, alu_ctl}, 64'h0);
      check("ready_at_done", {63'h0, req_ready}, 64'h1);
      check("busy_at_done", {63'h0, busy}, 64'h0);
      check_z();
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      check("done_pulse_len", {63'h0, done}, 64'h0);
      check("err_pulse_len", {63'h0, err}, 64'h0);
   endtask

   initial begin
      int done_seen;
      clr       = 1'b1;
      req_valid = 1'b0;
      req_ctl   = 4'h0;
      req_a     = 32'h0;
      req_b     = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clr = 1'b0;
      check("rst_ctl", {60'h0, alu_ctl}, 64'h0);
      check("rst_ready", {63'h0, req_ready}, 64'h1);
      check("rst_done", {63'h0, done}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_err", {63'h0, err}, 64'h0);
      check_z();

      run_op(4'd1, 32'd5, 32'd7, 1'b0);
      check("add_result", {z_hi, z_lo}, 64'd12);
      idle_cycle();

      run_op(4'd3, 32'h0001_0000, 32'h0001_0000, 1'b1);
      check("mul_result", {z_hi, z_lo}, 64'h1_0000_0000);
      idle_cycle();

      run_op(4'd0, 32'h1234, 32'h5678, 1'b0);
      idle_cycle();
      run_op(4'd13, 32'h1234, 32'h5678, 1'b0);
      check("illegal_keeps_z", {z_hi, z_lo}, 64'h1_0000_0000);
      idle_cycle();

      run_op(4'd9, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
      run_op(4'd9, 32'hFFFF_0000, 32'h00FF_FF00, 1'b0);
      idle_cycle();

      run_op(4'd2, 32'd100, 32'd100, 1'b0);
      check("sub_zero", {z_hi, z_lo}, 64'h0);
      run_op(4'd1, 32'd1, 32'd0, 1'b0);
      idle_cycle();

      // Reset mid-operation: divide abandoned during WAIT.
      req_valid = 1'b1;
      req_ctl   = 4'd4;
      req_a     = 32'd1000;
      req_b     = 32'd7;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      repeat (11) @(negedge clk);
      check("div_busy_before_clr", {63'h0, busy}, 64'h1);
      clr = 1'b1;
      @(posedge clk);
      @(negedge clk);
      clr    = 1'b0;
      exp_z  = 64'h0;
      exp_zz = 1'b0;
      check("clr_ready", {63'h0, req_ready}, 64'h1);
      check("clr_busy", {63'h0, busy}, 64'h0);
      check("clr_done", {63'h0, done}, 64'h0);
      check("clr_ctl", {60'h0, alu_ctl}, 64'h0);
      check("clr_alu_a", {32'h0, alu_a}, 64'h0);
      check_z();
      done_seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      check("clr_no_done", 64'(done_seen), 64'h0);

      for (int i = 0; i < 24; i++) begin
         logic [3:0]  c;
         logic [31:0] a;
         logic [31:0] b;
         c = 4'($urandom_range(0, 15));
         a = $urandom;
         b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         run_op(c, a, b, 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 1) == 1) idle_cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
